// File: rtl/fb_pkg.sv
// Shared frame buffer definitions for the drawing engine and the VGA signal
// generator: coordinate widths, visible area limits, the {Y, X} address
// packing and the rectangle writer state encoding.
package fb_pkg;

  localparam int X_BITS    = 8;
  localparam int Y_BITS    = 7;
  localparam int MAX_X     = 159;
  localparam int MAX_Y     = 119;
  localparam int ADDR_BITS = X_BITS + Y_BITS;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WAIT_VB = 3'd2,
    ST_DRAW    = 3'd3,
    ST_DONE    = 3'd4
  } fb_state_e;

  // Frame buffer address: row in the upper bits, column in the lower bits.
  function automatic logic [ADDR_BITS-1:0] fb_addr(input logic [Y_BITS-1:0] y,
                                                   input logic [X_BITS-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_rect_normalise.sv
// Combinational command normaliser for the rectangle writer.
// Substitutes full-screen corners for a clear, sorts the corners, clamps the
// far edges to the visible area and flags rectangles that start off-screen.
//
// Ports:
//   op_i            0 = fill rectangle, 1 = clear whole screen
//   x0_i/y0_i       corner A
//   x1_i/y1_i       corner B
//   xs_o/xe_o       sorted, clamped column range
//   ys_o/ye_o       sorted, clamped row range
//   empty_o         rectangle has no visible pixel
module fb_rect_normalise
  import fb_pkg::*;
#(
  parameter int X_BITS_P = X_BITS,
  parameter int Y_BITS_P = Y_BITS,
  parameter int MAX_X_P  = MAX_X,
  parameter int MAX_Y_P  = MAX_Y
) (
  input  logic                op_i,
  input  logic [X_BITS_P-1:0] x0_i,
  input  logic [Y_BITS_P-1:0] y0_i,
  input  logic [X_BITS_P-1:0] x1_i,
  input  logic [Y_BITS_P-1:0] y1_i,
  output logic [X_BITS_P-1:0] xs_o,
  output logic [X_BITS_P-1:0] xe_o,
  output logic [Y_BITS_P-1:0] ys_o,
  output logic [Y_BITS_P-1:0] ye_o,
  output logic                empty_o
);

  localparam logic [X_BITS_P-1:0] MAX_X_L = X_BITS_P'(MAX_X_P);
  localparam logic [Y_BITS_P-1:0] MAX_Y_L = Y_BITS_P'(MAX_Y_P);

  logic [X_BITS_P-1:0] ax0, ax1, lo_x, hi_x;
  logic [Y_BITS_P-1:0] ay0, ay1, lo_y, hi_y;

  always_comb begin
    ax0 = x0_i;
    ax1 = x1_i;
    ay0 = y0_i;
    ay1 = y1_i;
    if (op_i) begin
      ax0 = '0;
      ay0 = '0;
      ax1 = MAX_X_L;
      ay1 = MAX_Y_L;
    end

    lo_x = (ax0 < ax1) ? ax0 : ax1;
    hi_x = (ax0 < ax1) ? ax1 : ax0;
    lo_y = (ay0 < ay1) ? ay0 : ay1;
    hi_y = (ay0 < ay1) ? ay1 : ay0;

    xs_o = lo_x;
    ys_o = lo_y;
    xe_o = (hi_x > MAX_X_L) ? MAX_X_L : hi_x;
    ye_o = (hi_y > MAX_Y_L) ? MAX_Y_L : hi_y;

    // A start beyond the visible edge leaves nothing to draw; otherwise the
    // clamped end is still >= start because start itself is on-screen.
    empty_o = (lo_x > MAX_X_L) || (lo_y > MAX_Y_L);
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle fill / screen clear engine driving write port A of the 1-bit
// frame buffer, one pixel per clock in raster order.
//
// Ports:
//   CLK, RESETN            clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY    command handshake
//   CMD_OP                 0 = fill rectangle, 1 = clear whole screen
//   CMD_X0..CMD_Y1         rectangle corners
//   CMD_COLOUR             pixel value to write
//   VBLANK                 vertical blank level (already synchronised)
//   FB_WE/FB_ADDR/FB_DATA  frame buffer write port, address {Y, X}
//   BUSY                   command in progress (accept+1 through DONE)
//   DONE                   one-cycle completion pulse
//
// Handshake: a command transfers on a rising edge where CMD_VALID and
// CMD_READY are both high. CMD_READY is high only in IDLE and does not depend
// on CMD_VALID; command inputs are ignored at every other time.
//
// The write port is decoded straight from registered state so that reset
// removes FB_WE asynchronously. state_q is the engine state for observation.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int X_BITS_P       = X_BITS,
  parameter int Y_BITS_P       = Y_BITS,
  parameter int MAX_X_P        = MAX_X,
  parameter int MAX_Y_P        = MAX_Y,
  parameter bit SYNC_TO_VBLANK = 1'b0
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         CMD_VALID,
  output logic                         CMD_READY,
  input  logic                         CMD_OP,
  input  logic [X_BITS_P-1:0]          CMD_X0,
  input  logic [Y_BITS_P-1:0]          CMD_Y0,
  input  logic [X_BITS_P-1:0]          CMD_X1,
  input  logic [Y_BITS_P-1:0]          CMD_Y1,
  input  logic                         CMD_COLOUR,
  input  logic                         VBLANK,
  output logic                         FB_WE,
  output logic [Y_BITS_P+X_BITS_P-1:0] FB_ADDR,
  output logic                         FB_DATA,
  output logic                         BUSY,
  output logic                         DONE
);

  fb_state_e state_q, state_d;

  // Latched command (captured on accept, normalised during SETUP).
  logic                op_q, op_d;
  logic                colour_q, colour_d;
  logic [X_BITS_P-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [Y_BITS_P-1:0] y0_q, y0_d, y1_q, y1_d;

  // Normalised bounds and walk position.
  logic [X_BITS_P-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d;
  logic [Y_BITS_P-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d;

  logic [X_BITS_P-1:0] n_xs, n_xe;
  logic [Y_BITS_P-1:0] n_ys, n_ye;
  logic                n_empty;
  logic                accept;

  fb_rect_normalise #(
    .X_BITS_P (X_BITS_P),
    .Y_BITS_P (Y_BITS_P),
    .MAX_X_P  (MAX_X_P),
    .MAX_Y_P  (MAX_Y_P)
  ) u_norm (
    .op_i    (op_q),
    .x0_i    (x0_q),
    .y0_i    (y0_q),
    .x1_i    (x1_q),
    .y1_i    (y1_q),
    .xs_o    (n_xs),
    .xe_o    (n_xe),
    .ys_o    (n_ys),
    .ye_o    (n_ye),
    .empty_o (n_empty)
  );

  assign accept = CMD_VALID && (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    colour_d = colour_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    xs_d     = xs_q;
    xe_d     = xe_q;
    ys_d     = ys_q;
    ye_d     = ye_q;
    x_d      = x_q;
    y_d      = y_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d     = CMD_OP;
          colour_d = CMD_COLOUR;
          x0_d     = CMD_X0;
          y0_d     = CMD_Y0;
          x1_d     = CMD_X1;
          y1_d     = CMD_Y1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        xs_d = n_xs;
        xe_d = n_xe;
        ys_d = n_ys;
        ye_d = n_ye;
        x_d  = n_xs;
        y_d  = n_ys;
        if (n_empty)                      state_d = ST_DONE;
        else if (SYNC_TO_VBLANK && !VBLANK) state_d = ST_WAIT_VB;
        else                              state_d = ST_DRAW;
      end
      ST_WAIT_VB: begin
        if (VBLANK) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        // Equality end tests keep the counters inside xs..xe / ys..ye,
        // so they never wrap.
        if (x_q == xe_q) begin
          if (y_q == ye_q) begin
            state_d = ST_DONE;
          end else begin
            x_d = xs_q;
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_IDLE;
      op_q     <= 1'b0;
      colour_q <= 1'b0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      xs_q     <= '0;
      xe_q     <= '0;
      ys_q     <= '0;
      ye_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      colour_q <= colour_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      xs_q     <= xs_d;
      xe_q     <= xe_d;
      ys_q     <= ys_d;
      ye_q     <= ye_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_DONE);
  assign FB_WE     = (state_q == ST_DRAW);
  assign FB_ADDR   = FB_WE ? {y_q, x_q} : '0;
  assign FB_DATA   = FB_WE & colour_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
module tb_fb_rect_writer;

  int checks = 0;
  int errors = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [6:0] cmd_y0 = '0, cmd_y1 = '0;
  logic       cmd_colour = 1'b0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       vb0 = 1'b0, vb1 = 1'b0;

  logic        ready0, we0, data0, busy0, done0;
  logic        ready1, we1, data1, busy1, done1;
  logic [14:0] addr0, addr1;

  // Scoreboard and capture results.
  logic [14:0] exp_q[$];
  logic [14:0] cap_addr[$];
  logic        cap_data[$];
  int          cap_first, cap_done, cap_cnt;
  bit          cap_gap, cap_busy_done;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fb_rect_writer dut (
    .CLK(clk), .RESETN(rst_n), .CMD_VALID(valid0), .CMD_READY(ready0),
    .CMD_OP(cmd_op), .CMD_X0(cmd_x0), .CMD_Y0(cmd_y0), .CMD_X1(cmd_x1),
    .CMD_Y1(cmd_y1), .CMD_COLOUR(cmd_colour), .VBLANK(vb0), .FB_WE(we0),
    .FB_ADDR(addr0), .FB_DATA(data0), .BUSY(busy0), .DONE(done0)
  );

  fb_rect_writer #(.SYNC_TO_VBLANK(1'b1)) dut_vb (
    .CLK(clk), .RESETN(rst_n), .CMD_VALID(valid1), .CMD_READY(ready1),
    .CMD_OP(cmd_op), .CMD_X0(cmd_x0), .CMD_Y0(cmd_y0), .CMD_X1(cmd_x1),
    .CMD_Y1(cmd_y1), .CMD_COLOUR(cmd_colour), .VBLANK(vb1), .FB_WE(we1),
    .FB_ADDR(addr1), .FB_DATA(data1), .BUSY(busy1), .DONE(done1)
  );

  // ---------------- driver / model tasks ----------------
  // Presents a command at a falling edge; it transfers on the next rising
  // edge. Returns 1 time unit after that edge.
  task automatic send_cmd(input bit sel, input bit op, input int x0, input int y0,
                          input int x1, input int y1, input bit col, input bit hold);
    @(negedge clk);
    cmd_op = op; cmd_x0 = 8'(x0); cmd_y0 = 7'(y0);
    cmd_x1 = 8'(x1); cmd_y1 = 7'(y1); cmd_colour = col;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      valid0 = 1'b0;
      valid1 = 1'b0;
    end
  endtask

  // Records every write, cycle index k counted from the accept edge
  // (k = 1 is the cycle right after it), until DONE or budget expiry.
  task automatic capture(input bit sel, input int budget);
    int last_k;
    bit we, dn;
    last_k = -1;
    cap_first = -1; cap_done = -1; cap_cnt = 0; cap_gap = 0; cap_busy_done = 0;
    cap_addr.delete(); cap_data.delete();
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      we = sel ? we1 : we0;
      dn = sel ? done1 : done0;
      if (we) begin
        if (last_k >= 0 && last_k != k - 1) cap_gap = 1;
        if (cap_first < 0) cap_first = k;
        last_k = k;
        cap_cnt++;
        cap_addr.push_back(sel ? addr1 : addr0);
        cap_data.push_back(sel ? data1 : data0);
      end
      if (dn) begin
        cap_done = k;
        cap_busy_done = sel ? busy1 : busy0;
        break;
      end
    end
  endtask

  // Raster-order reference for a rectangle with hand-computed bounds.
  task automatic build_exp(input int xs, input int xe, input int ys, input int ye);
    exp_q.delete();
    for (int y = ys; y <= ye; y++)
      for (int x = xs; x <= xe; x++)
        exp_q.push_back({7'(y), 8'(x)});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready0); end
    checks++; if (we0 !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we0); end
    checks++; if (addr0 !== 15'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr0); end
    checks++; if (data0 !== 1'b0) begin errors++; $display("FAIL reset_data: got %b want 0", data0); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy0, done0); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready0 !== 1'b1 || busy0 !== 1'b0 || we0 !== 1'b0) begin errors++; $display("FAIL post_reset_idle: rdy %b busy %b we %b want 1 0 0", ready0, busy0, we0); end
  endtask

  task automatic test_fill_small;
    send_cmd(0, 0, 2, 3, 4, 4, 1, 0);
    capture(0, 50);
    build_exp(2, 4, 3, 4);
    checks++; if (cap_cnt != 6) begin errors++; $display("FAIL small_count: got %0d want 6", cap_cnt); end
    checks++; if (cap_first != 2) begin errors++; $display("FAIL small_first_we: got %0d want 2", cap_first); end
    checks++; if (cap_done != 8) begin errors++; $display("FAIL small_done_cycle: got %0d want 8", cap_done); end
    checks++; if (cap_gap) begin errors++; $display("FAIL small_consecutive: got gap want none"); end
    checks++; if (cap_busy_done !== 1'b1) begin errors++; $display("FAIL small_busy_at_done: got %b want 1", cap_busy_done); end
    checks++; if (cap_addr.size() > 0 && cap_addr[0] !== 15'd770) begin errors++; $display("FAIL small_first_addr: got %0d want 770", cap_addr[0]); end
    checks++; if (cap_addr.size() > 5 && cap_addr[5] !== 15'd1028) begin errors++; $display("FAIL small_last_addr: got %0d want 1028", cap_addr[5]); end
    for (int i = 0; i < exp_q.size() && i < cap_addr.size(); i++) begin
      checks++; if (cap_addr[i] !== exp_q[i]) begin errors++; $display("FAIL small_addr[%0d]: got %0d want %0d", i, cap_addr[i], exp_q[i]); end
      checks++; if (cap_data[i] !== 1'b1) begin errors++; $display("FAIL small_data[%0d]: got %b want 1", i, cap_data[i]); end
    end
    @(negedge clk);
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL small_after_done: busy %b done %b want 0 0", busy0, done0); end
  endtask

  task automatic test_swapped_and_clipped;
    send_cmd(0, 0, 10, 5, 8, 5, 1, 0);
    capture(0, 50);
    build_exp(8, 10, 5, 5);
    checks++; if (cap_cnt != 3) begin errors++; $display("FAIL swap_count: got %0d want 3", cap_cnt); end
    checks++; if (cap_done != 5) begin errors++; $display("FAIL swap_done_cycle: got %0d want 5", cap_done); end
    for (int i = 0; i < exp_q.size() && i < cap_addr.size(); i++) begin
      checks++; if (cap_addr[i] !== exp_q[i]) begin errors++; $display("FAIL swap_addr[%0d]: got %0d want %0d", i, cap_addr[i], exp_q[i]); end
    end

    send_cmd(0, 0, 150, 110, 200, 127, 1, 0);
    capture(0, 200);
    build_exp(150, 159, 110, 119);
    checks++; if (cap_cnt != 100) begin errors++; $display("FAIL clip_count: got %0d want 100", cap_cnt); end
    checks++; if (cap_done != 102) begin errors++; $display("FAIL clip_done_cycle: got %0d want 102", cap_done); end
    checks++; if (cap_addr.size() > 0 && cap_addr[0] !== 15'd28310) begin errors++; $display("FAIL clip_first_addr: got %0d want 28310", cap_addr[0]); end
    checks++; if (cap_addr.size() == 100 && cap_addr[99] !== 15'd30623) begin errors++; $display("FAIL clip_last_addr: got %0d want 30623", cap_addr[99]); end
    for (int i = 0; i < exp_q.size() && i < cap_addr.size(); i++) begin
      checks++; if (cap_addr[i] !== exp_q[i]) begin errors++; $display("FAIL clip_addr[%0d]: got %0d want %0d", i, cap_addr[i], exp_q[i]); end
    end
  endtask

  task automatic test_offscreen;
    send_cmd(0, 0, 170, 0, 200, 10, 1, 0);
    capture(0, 20);
    checks++; if (cap_cnt != 0) begin errors++; $display("FAIL offscreen_count: got %0d want 0", cap_cnt); end
    checks++; if (cap_done != 2) begin errors++; $display("FAIL offscreen_done_cycle: got %0d want 2", cap_done); end
  endtask

  task automatic test_clear_back_to_back;
    // CMD_VALID stays high; the fields change after accept and must be
    // ignored until the engine is idle again.
    send_cmd(0, 1, 30, 30, 40, 40, 0, 1);
    cmd_op = 1'b0; cmd_x0 = 8'd1; cmd_y0 = 7'd1; cmd_x1 = 8'd1; cmd_y1 = 7'd1; cmd_colour = 1'b1;
    capture(0, 19300);
    build_exp(0, 159, 0, 119);
    checks++; if (cap_cnt != 19200) begin errors++; $display("FAIL clear_count: got %0d want 19200", cap_cnt); end
    checks++; if (cap_done != 19202) begin errors++; $display("FAIL clear_done_cycle: got %0d want 19202", cap_done); end
    checks++; if (cap_gap) begin errors++; $display("FAIL clear_consecutive: got gap want none"); end
    for (int i = 0; i < exp_q.size() && i < cap_addr.size(); i++) begin
      checks++; if (cap_addr[i] !== exp_q[i] || cap_data[i] !== 1'b0) begin
        errors++; $display("FAIL clear_write[%0d]: got %0d/%b want %0d/0", i, cap_addr[i], cap_data[i], exp_q[i]);
      end
    end
    @(negedge clk);
    checks++; if (ready0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL clear_return_idle: rdy %b busy %b want 1 0", ready0, busy0); end
    @(posedge clk);
    #1 valid0 = 1'b0;
    capture(0, 20);
    checks++; if (cap_cnt != 1) begin errors++; $display("FAIL reaccept_count: got %0d want 1", cap_cnt); end
    checks++; if (cap_addr.size() > 0 && (cap_addr[0] !== 15'd257 || cap_data[0] !== 1'b1)) begin
      errors++; $display("FAIL reaccept_write: got %0d/%b want 257/1", cap_addr[0], cap_data[0]);
    end
    checks++; if (cap_done != 3) begin errors++; $display("FAIL reaccept_done_cycle: got %0d want 3", cap_done); end
  endtask

  task automatic test_vblank_sync;
    vb1 = 1'b0;
    send_cmd(1, 0, 0, 0, 3, 1, 1, 0);
    fork
      begin
        repeat (50) @(posedge clk);
        #1 vb1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 vb1 = 1'b0;
      end
      capture(1, 200);
    join
    build_exp(0, 3, 0, 1);
    checks++; if (cap_first != 52) begin errors++; $display("FAIL vb_first_we: got %0d want 52", cap_first); end
    checks++; if (cap_cnt != 8) begin errors++; $display("FAIL vb_count: got %0d want 8", cap_cnt); end
    checks++; if (cap_gap) begin errors++; $display("FAIL vb_no_stall: got gap want none"); end
    checks++; if (cap_done != 60) begin errors++; $display("FAIL vb_done_cycle: got %0d want 60", cap_done); end
    for (int i = 0; i < exp_q.size() && i < cap_addr.size(); i++) begin
      checks++; if (cap_addr[i] !== exp_q[i]) begin errors++; $display("FAIL vb_addr[%0d]: got %0d want %0d", i, cap_addr[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_fill;
    bit saw_done;
    send_cmd(0, 0, 0, 0, 9, 9, 1, 0);
    repeat (20) @(negedge clk);
    checks++; if (we0 !== 1'b1) begin errors++; $display("FAIL midfill_active: we %b want 1", we0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (we0 !== 1'b0 || addr0 !== 15'd0 || data0 !== 1'b0) begin
      errors++; $display("FAIL midfill_async_we: we %b addr %0d data %b want 0 0 0", we0, addr0, data0);
    end
    checks++; if (busy0 !== 1'b0 || ready0 !== 1'b1) begin errors++; $display("FAIL midfill_async_state: busy %b rdy %b want 0 1", busy0, ready0); end
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done0) saw_done = 1;
    end
    rst_n = 1'b1;
    #1;
    checks++; if (saw_done || done0 !== 1'b0) begin errors++; $display("FAIL midfill_no_done: got pulse want none"); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL midfill_ready_after: got %b want 1", ready0); end
    send_cmd(0, 0, 5, 5, 6, 5, 1, 0);
    capture(0, 20);
    checks++; if (cap_cnt != 2 || cap_done != 4) begin errors++; $display("FAIL post_reset_cmd: count %0d done %0d want 2 4", cap_cnt, cap_done); end
    checks++; if (cap_addr.size() == 2 && (cap_addr[0] !== 15'd1285 || cap_addr[1] !== 15'd1286)) begin
      errors++; $display("FAIL post_reset_addr: got %0d %0d want 1285 1286", cap_addr[0], cap_addr[1]);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill_small();
    test_swapped_and_clipped();
    test_offscreen();
    test_clear_back_to_back();
    test_vblank_sync();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
